// File: rtl/oled_frame_sequencer.sv
// Feeds the I2C OLED master byte by byte: power-up wait, SSD1306 init, window setup and framebuffer upload.
// Idle time is filled with single-byte NOP command transactions so the free-running master always has work.
module oled_frame_sequencer #(
    parameter logic [6:0] OLED_ADDR      = 7'h3C,
    parameter int         POWERUP_CYCLES = 100000,
    parameter int         FB_BYTES       = 1024,
    parameter bit         AUTO_REFRESH   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i2c_state,
    output logic [6:0] addr_byte,
    output logic       read_write,
    output logic [7:0] control_byte,
    output logic [7:0] data_byte,
    output logic       continue_bit,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_data,
    input  logic       frame_req,
    output logic       frame_done,
    output logic       init_done,
    output logic       busy
);

    // state   | meaning
    // P_WAIT  | power-up delay, NOP transactions until the counter expires
    // P_INIT  | one 25-byte SSD1306 init command transaction
    // P_ADDR  | column/page window setup before each frame
    // P_FRAME | framebuffer upload, control 0x40
    // P_HOLD  | idle between frames (AUTO_REFRESH=0), NOPs until a request
    typedef enum logic [2:0] {
        P_WAIT  = 3'd0,
        P_INIT  = 3'd1,
        P_ADDR  = 3'd2,
        P_FRAME = 3'd3,
        P_HOLD  = 3'd4
    } phase_t;

    localparam logic [3:0] ST_START   = 4'd1;
    localparam logic [3:0] ST_WR_DATA = 4'd4;
    localparam logic [3:0] ST_ACK     = 4'd6;
    localparam logic [3:0] ST_STOP    = 4'd8;

    localparam logic [4:0] INIT_LAST = 5'd24;
    localparam logic [4:0] ADDR_LAST = 5'd5;
    localparam logic [9:0] FB_LAST   = 10'(FB_BYTES - 1);
    localparam logic [7:0] NOP_CMD   = 8'hE3;
    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;

    localparam int WAIT_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(POWERUP_CYCLES);

    phase_t            phase, phase_next;
    logic [4:0]        idx, idx_next;
    logic [9:0]        fb_addr_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [3:0]        i2c_state_q;
    logic              consume, abort;
    logic              xfer_open;
    logic              req_q, req_clr;
    logic              frame_done_next, init_done_next;
    logic [7:0]        control_next, data_next;
    logic              continue_next;

    function automatic logic [7:0] init_rom(input logic [4:0] i);
        logic [7:0] b;
        case (i)
            5'd0:  b = 8'hAE;
            5'd1:  b = 8'hD5;
            5'd2:  b = 8'h80;
            5'd3:  b = 8'hA8;
            5'd4:  b = 8'h3F;
            5'd5:  b = 8'hD3;
            5'd6:  b = 8'h00;
            5'd7:  b = 8'h40;
            5'd8:  b = 8'h8D;
            5'd9:  b = 8'h14;
            5'd10: b = 8'h20;
            5'd11: b = 8'h00;
            5'd12: b = 8'hA1;
            5'd13: b = 8'hC8;
            5'd14: b = 8'hDA;
            5'd15: b = 8'h12;
            5'd16: b = 8'h81;
            5'd17: b = 8'hCF;
            5'd18: b = 8'hD9;
            5'd19: b = 8'hF1;
            5'd20: b = 8'hDB;
            5'd21: b = 8'h40;
            5'd22: b = 8'hA4;
            5'd23: b = 8'hA6;
            5'd24: b = 8'hAF;
            default: b = NOP_CMD;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] window_rom(input logic [4:0] i);
        logic [7:0] b;
        case (i)
            5'd0: b = 8'h21;
            5'd1: b = 8'h00;
            5'd2: b = 8'h7F;
            5'd3: b = 8'h22;
            5'd4: b = 8'h00;
            5'd5: b = 8'h07;
            default: b = NOP_CMD;
        endcase
        return b;
    endfunction

    assign addr_byte  = OLED_ADDR;
    assign read_write = 1'b0;
    assign busy       = (phase != P_HOLD);

    // continue_bit already holds the preloaded next byte when STOP arrives, so an early STOP is judged
    // against the continue flag of the byte actually sent (xfer_open), not the preloaded one.
    assign consume = (i2c_state_q == ST_WR_DATA) && (i2c_state == ST_ACK);
    assign abort   = (i2c_state == ST_STOP) && (i2c_state_q != ST_STOP) && xfer_open;

    always_comb begin
        phase_next      = phase;
        idx_next        = idx;
        fb_addr_next    = fb_addr;
        req_clr         = 1'b0;
        frame_done_next = 1'b0;
        init_done_next  = init_done;

        if (abort) begin
            case (phase)
                P_INIT: idx_next = 5'd0;
                P_ADDR, P_FRAME: begin
                    phase_next   = P_ADDR;
                    idx_next     = 5'd0;
                    fb_addr_next = 10'd0;
                end
                default: ;
            endcase
        end else if (consume) begin
            case (phase)
                P_WAIT: begin
                    if (wait_cnt == '0) begin
                        phase_next = P_INIT;
                        idx_next   = 5'd0;
                    end
                end
                P_INIT: begin
                    if (idx == INIT_LAST) begin
                        phase_next     = P_ADDR;
                        idx_next       = 5'd0;
                        init_done_next = 1'b1;
                        req_clr        = 1'b1;
                    end else begin
                        idx_next = idx + 5'd1;
                    end
                end
                P_ADDR: begin
                    if (idx == ADDR_LAST) begin
                        phase_next   = P_FRAME;
                        idx_next     = 5'd0;
                        fb_addr_next = 10'd0;
                    end else begin
                        idx_next = idx + 5'd1;
                    end
                end
                P_FRAME: begin
                    if (fb_addr == FB_LAST) begin
                        frame_done_next = 1'b1;
                        fb_addr_next    = 10'd0;
                        idx_next        = 5'd0;
                        if (AUTO_REFRESH || req_q) begin
                            phase_next = P_ADDR;
                            req_clr    = 1'b1;
                        end else begin
                            phase_next = P_HOLD;
                        end
                    end else begin
                        fb_addr_next = fb_addr + 10'd1;
                    end
                end
                P_HOLD: begin
                    if (req_q) begin
                        phase_next = P_ADDR;
                        idx_next   = 5'd0;
                        req_clr    = 1'b1;
                    end
                end
                default: phase_next = P_WAIT;
            endcase
        end

        // Byte presented to the master; registered, so it settles one clk after the phase/idx update
        // (two clk in P_FRAME because of the RAM read latency).
        control_next  = CTRL_CMD;
        data_next     = NOP_CMD;
        continue_next = 1'b0;
        case (phase)
            P_INIT: begin
                data_next     = init_rom(idx);
                continue_next = (idx != INIT_LAST);
            end
            P_ADDR: begin
                data_next     = window_rom(idx);
                continue_next = (idx != ADDR_LAST);
            end
            P_FRAME: begin
                control_next  = CTRL_DATA;
                data_next     = fb_data;
                continue_next = (fb_addr != FB_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= P_WAIT;
            idx          <= 5'd0;
            fb_addr      <= 10'd0;
            wait_cnt     <= WAIT_LOAD;
            i2c_state_q  <= 4'd0;
            xfer_open    <= 1'b0;
            req_q        <= 1'b0;
            frame_done   <= 1'b0;
            init_done    <= 1'b0;
            control_byte <= CTRL_CMD;
            data_byte    <= NOP_CMD;
            continue_bit <= 1'b0;
        end else begin
            phase        <= phase_next;
            idx          <= idx_next;
            fb_addr      <= fb_addr_next;
            i2c_state_q  <= i2c_state;
            req_q        <= (req_q && !req_clr) || frame_req;
            frame_done   <= frame_done_next;
            init_done    <= init_done_next;
            control_byte <= control_next;
            data_byte    <= data_next;
            continue_bit <= continue_next;
            if (phase == P_WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - WAIT_W'(1);
            if (i2c_state == ST_START && i2c_state_q != ST_START)
                xfer_open <= 1'b1;
            else if (consume)
                xfer_open <= continue_bit;
        end
    end

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Bench for oled_frame_sequencer: a behavioural I2C master walks each transaction and checks every byte
// it latches against a queue of expected bytes pushed by the scenario tasks.
module tb_oled_frame_sequencer;

    localparam int POWERUP = 50;
    localparam int FB      = 1024;
    localparam int HOLD    = 3;

    typedef struct packed {
        logic [7:0] ctrl;
        logic [7:0] data;
        logic       cont;
    } byte_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] i2c_state = 4'd0;
    logic [6:0] addr_byte;
    logic       read_write;
    logic [7:0] control_byte;
    logic [7:0] data_byte;
    logic       continue_bit;
    logic [9:0] fb_addr;
    logic [7:0] fb_data = 8'h00;
    logic       frame_req = 1'b0;
    logic       frame_done;
    logic       init_done;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int cons_cyc = 0;
    int fd_pulses = 0;
    int fd_high = 0;
    logic fd_prev = 1'b0;

    byte_t sb[$];
    logic [7:0] init_rom [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                                  8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                                  8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] win_rom [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    oled_frame_sequencer #(
        .OLED_ADDR(7'h3C),
        .POWERUP_CYCLES(POWERUP),
        .FB_BYTES(FB),
        .AUTO_REFRESH(1'b0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i2c_state(i2c_state),
        .addr_byte(addr_byte),
        .read_write(read_write),
        .control_byte(control_byte),
        .data_byte(data_byte),
        .continue_bit(continue_bit),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .frame_req(frame_req),
        .frame_done(frame_done),
        .init_done(init_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Framebuffer RAM whose contents are addr[7:0], one clk read latency.
    always @(posedge clk) fb_data <= fb_addr[7:0];

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (frame_done) fd_high = fd_high + 1;
        if (frame_done && !fd_prev) fd_pulses = fd_pulses + 1;
        fd_prev = frame_done;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic step(input logic [3:0] s);
        i2c_state = s;
        if (s == 4'd6) cons_cyc = cyc;
        repeat (HOLD) @(posedge clk);
        #1;
    endtask

    task automatic push_nop();
        byte_t b;
        b = {8'h00, 8'hE3, 1'b0};
        sb.push_back(b);
    endtask

    task automatic push_init();
        byte_t b;
        for (int i = 0; i < 25; i++) begin
            b = {8'h00, init_rom[i], (i != 24)};
            sb.push_back(b);
        end
    endtask

    task automatic push_addr();
        byte_t b;
        for (int i = 0; i < 6; i++) begin
            b = {8'h00, win_rom[i], (i != 5)};
            sb.push_back(b);
        end
    endtask

    task automatic push_frame(input int last);
        byte_t b;
        logic [9:0] a;
        for (int i = 0; i <= last; i++) begin
            a = 10'(i);
            b = {8'h40, a[7:0], (i != FB - 1)};
            sb.push_back(b);
        end
    endtask

    // Master model: START, RECOG, RECOG_ACK, WR_CTRL, ACK, [WR_DATA, ACK]*, STOP, IDLE.
    // nack_at: byte index after which the slave NACKs; cut_at: abandon the transaction there.
    task automatic run_txn(input int nack_at, input int cut_at);
        byte_t got, exp;
        logic more;
        int n;
        step(4'd1); step(4'd2); step(4'd7); step(4'd3); step(4'd6);
        n = 0;
        more = 1'b1;
        while (more && n < 1100) begin
            step(4'd4);
            got = {control_byte, data_byte, continue_bit};
            more = continue_bit;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: got ctrl %h data %h cont %b, required a queued byte",
                         got.ctrl, got.data, got.cont);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL byte%0d: got ctrl %h data %h cont %b, required ctrl %h data %h cont %b",
                             n, got.ctrl, got.data, got.cont, exp.ctrl, exp.data, exp.cont);
                end
            end
            step(4'd6);
            if (n == cut_at) return;
            if (n == nack_at) more = 1'b0;
            n++;
        end
        if (n >= 1100) begin
            n_cmp++; n_err++;
            $display("FAIL txn_len: got more than %0d bytes, required a terminating cont 0", n);
        end
        step(4'd8); step(4'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i2c_state = 4'd0;
        frame_req = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({addr_byte, read_write, control_byte, data_byte, continue_bit} !== {7'h3C, 1'b0, 8'h00, 8'hE3, 1'b0}) begin
            n_err++;
            $display("FAIL reset_bytes: got addr %h rw %b ctrl %h data %h cont %b, required 3c 0 00 e3 0",
                     addr_byte, read_write, control_byte, data_byte, continue_bit);
        end
        n_cmp++;
        if ({fb_addr, frame_done, init_done, busy} !== {10'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_status: got fb_addr %0d fd %b id %b busy %b, required 0 0 0 1",
                     fb_addr, frame_done, init_done, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_powerup_init();
        int k;
        cons_cyc = 0;
        k = 0;
        while (k < 10 && !(k > 0 && cons_cyc >= POWERUP)) begin
            push_nop();
            run_txn(-1, -1);
            k++;
        end
        n_cmp++;
        if (init_done !== 1'b0) begin
            n_err++;
            $display("FAIL init_done_early: got %b, required 0", init_done);
        end
        push_init();
        run_txn(-1, -1);
        n_cmp++;
        if (init_done !== 1'b1) begin
            n_err++;
            $display("FAIL init_done: got %b, required 1", init_done);
        end
    endtask

    task automatic test_addr_frame();
        int p0, h0;
        push_addr();
        run_txn(-1, -1);
        p0 = fd_pulses;
        h0 = fd_high;
        push_frame(FB - 1);
        run_txn(-1, -1);
        n_cmp++;
        if (fd_pulses - p0 != 1 || fd_high - h0 != 1) begin
            n_err++;
            $display("FAIL frame_done_pulse: got %0d pulses %0d high clk, required 1 and 1",
                     fd_pulses - p0, fd_high - h0);
        end
        n_cmp++;
        if (fb_addr !== 10'd0) begin
            n_err++;
            $display("FAIL fb_addr_wrap: got %0d, required 0", fb_addr);
        end
    endtask

    task automatic test_hold_request();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL hold_busy: got %b, required 0", busy);
        end
        push_nop();
        run_txn(-1, -1);
        push_nop();
        fork
            run_txn(-1, -1);
            begin
                repeat (10) @(negedge clk);
                frame_req = 1'b1;
                @(negedge clk);
                frame_req = 1'b0;
            end
        join
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL req_busy: got %b, required 1", busy);
        end
        push_addr();
        run_txn(-1, -1);
    endtask

    task automatic test_abort();
        int p0;
        p0 = fd_pulses;
        push_frame(500);
        run_txn(500, -1);
        n_cmp++;
        if (fd_pulses != p0) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d pulses, required 0", fd_pulses - p0);
        end
        n_cmp++;
        if (fb_addr !== 10'd0) begin
            n_err++;
            $display("FAIL abort_fb_addr: got %0d, required 0", fb_addr);
        end
        push_addr();
        run_txn(-1, -1);
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = fd_pulses;
        push_frame(FB - 1);
        fork
            run_txn(-1, -1);
            begin
                repeat (200) @(negedge clk);
                frame_req = 1'b1;
                @(negedge clk);
                frame_req = 1'b0;
            end
        join
        n_cmp++;
        if (fd_pulses - p0 != 1) begin
            n_err++;
            $display("FAIL sticky_done: got %0d pulses, required 1", fd_pulses - p0);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL sticky_busy: got %b, required 1", busy);
        end
        push_addr();
        run_txn(-1, -1);
    endtask

    task automatic test_reset_mid_frame();
        push_frame(300);
        run_txn(-1, 300);
        n_cmp++;
        if (fb_addr !== 10'd301 || init_done !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: got fb_addr %0d init_done %b, required 301 1", fb_addr, init_done);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({control_byte, data_byte, continue_bit, fb_addr, frame_done, init_done, busy} !==
            {8'h00, 8'hE3, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL mid_reset: got ctrl %h data %h cont %b fb_addr %0d fd %b id %b busy %b, required 00 e3 0 0 0 0 1",
                     control_byte, data_byte, continue_bit, fb_addr, frame_done, init_done, busy);
        end
        i2c_state = 4'd0;
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_powerup_init();
        push_addr();
        run_txn(-1, -1);
    endtask

    initial begin
        test_reset();
        test_powerup_init();
        test_addr_frame();
        test_hold_request();
        test_abort();
        test_back_to_back();
        test_reset_mid_frame();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d unconsumed bytes, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
